// File: rtl/uart_host_model_pkg.sv
// Shared constants for the UART host-side model.
// Error flag bit positions and default byte width.
package uart_host_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int ERR_W      = 4;

  localparam int ERR_LOAD_OVF = 0;
  localparam int ERR_RX_UNDER = 1;
  localparam int ERR_TX_OVR   = 2;
  localparam int ERR_TIMEOUT  = 3;

endpackage

// File: rtl/uart_host_model_if.sv
// CPU-facing UART FIFO pair: RX pop side and TX push side.
// master = cpu, slave = host model.
interface uart_host_model_if #(
  parameter int DATA_W = 8
) ();

  logic [DATA_W-1:0] rx_data;
  logic              empty;
  logic              rd_en;
  logic [DATA_W-1:0] tx_data;
  logic              full;
  logic              wr_en;

  modport master (
    input  rx_data, empty, full,
    output rd_en, tx_data, wr_en
  );

  modport slave (
    output rx_data, empty, full,
    input  rd_en, tx_data, wr_en
  );

endinterface

// File: rtl/uart_host_model_sync_fifo.sv
// First-word-fall-through FIFO with exact occupancy count.
// Pointers carry an extra MSB to tell full from empty.
module sync_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full,
  output logic [AW:0]  count
);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         pop_ok;
  logic         push_ok;

  assign count = wptr - rptr;
  assign empty = (wptr == rptr);
  assign full  = (count == (AW+1)'(DEPTH));
  assign dout  = mem[rptr[AW-1:0]];

  // a pop in the same cycle frees the slot a full push needs
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wptr[AW-1:0]] <= din;
        wptr <= wptr + 1'b1;
      end
      if (pop_ok)
        rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_host_model.sv
// Host-side model of the cpu UART FIFO pair: RX buffer, TX log,
// injected TX backpressure, sticky protocol errors, idle timeout.
module uart_host_model
  import uart_host_pkg::*;
#(
  parameter  int DATA_W      = DEF_DATA_W,
  parameter  int RX_DEPTH    = 256,
  parameter  int TX_DEPTH    = 256,
  parameter  int FULL_PERIOD = 0,
  parameter  int TIMEOUT     = 200,
  localparam int RXC_W = $clog2(RX_DEPTH) + 1,
  localparam int TXC_W = $clog2(TX_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rstn,
  uart_host_model_if.slave  cpu,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              log_rd_en,
  output logic [DATA_W-1:0] log_data,
  output logic              log_empty,
  output logic [RXC_W-1:0]  rx_count,
  output logic [TXC_W-1:0]  tx_count,
  output logic [ERR_W-1:0]  err
);

  localparam int PW =
    (FULL_PERIOD > 1) ? $clog2(FULL_PERIOD) : 1;
  localparam logic [PW-1:0] PH_LAST =
    (FULL_PERIOD > 1) ? PW'(FULL_PERIOD - 1) : '0;
  localparam int IW = $clog2(TIMEOUT + 2);
  localparam logic [IW-1:0] IDLE_LAST =
    (TIMEOUT > 0) ? IW'(TIMEOUT - 1) : '0;

  logic             rx_empty;
  logic             rx_full;
  logic             rx_pop_ok;
  logic             log_full;
  logic             inject;
  logic             full;
  logic             tx_push;
  logic             activity;
  logic [PW-1:0]    phase;
  logic [IW-1:0]    idle;
  logic [ERR_W-1:0] err_set;

  sync_fifo #(
    .W     (DATA_W),
    .DEPTH (RX_DEPTH)
  ) u_rx (
    .clk   (clk),
    .rstn  (rstn),
    .push  (load_valid),
    .din   (load_data),
    .pop   (cpu.rd_en),
    .dout  (cpu.rx_data),
    .empty (rx_empty),
    .full  (rx_full),
    .count (rx_count)
  );

  sync_fifo #(
    .W     (DATA_W),
    .DEPTH (TX_DEPTH)
  ) u_tx (
    .clk   (clk),
    .rstn  (rstn),
    .push  (tx_push),
    .din   (cpu.tx_data),
    .pop   (log_rd_en),
    .dout  (log_data),
    .empty (log_empty),
    .full  (log_full),
    .count (tx_count)
  );

  assign inject    = (FULL_PERIOD > 1) && (phase == PH_LAST);
  assign full      = log_full | inject;
  assign cpu.full  = full;
  assign cpu.empty = rx_empty;
  assign rx_pop_ok = cpu.rd_en & ~rx_empty;
  assign tx_push   = cpu.wr_en & ~full;
  assign activity  = rx_pop_ok | tx_push;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      phase <= '0;
    else if (inject)
      phase <= '0;
    else if (FULL_PERIOD > 1)
      phase <= phase + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      idle <= '0;
    else if (activity)
      idle <= '0;
    else if (idle != '1)
      idle <= idle + 1'b1;
  end

  always_comb begin
    err_set = '0;
    err_set[ERR_LOAD_OVF] = load_valid & rx_full & ~rx_pop_ok;
    err_set[ERR_RX_UNDER] = cpu.rd_en & rx_empty;
    err_set[ERR_TX_OVR]   = cpu.wr_en & full;
    err_set[ERR_TIMEOUT]  = (TIMEOUT > 0) &&
                            (idle == IDLE_LAST) && !activity;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      err <= '0;
    else
      err <= err | err_set;
  end

endmodule

// File: tb/tb_uart_host_model.sv
// Directed bench: instance a (FULL_PERIOD=4, TIMEOUT=200),
// instance b (no backpressure, timeout disabled), shared stimulus.
module tb_uart_host_model;
  import uart_host_pkg::*;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = '0;
  logic       rd_en = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] tx_data = '0;
  logic       log_rd_en = 1'b0;

  always #5 clk = ~clk;

  uart_host_model_if #(.DATA_W(8)) if_a ();
  uart_host_model_if #(.DATA_W(8)) if_b ();

  assign if_a.rd_en   = rd_en;
  assign if_a.wr_en   = wr_en;
  assign if_a.tx_data = tx_data;
  assign if_b.rd_en   = rd_en;
  assign if_b.wr_en   = wr_en;
  assign if_b.tx_data = tx_data;

  logic [7:0] a_log_data, b_log_data;
  logic       a_log_empty, b_log_empty;
  logic [3:0] a_rx_count;
  logic [2:0] b_rx_count;
  logic [5:0] a_tx_count, b_tx_count;
  logic [3:0] a_err, b_err;

  uart_host_model #(
    .DATA_W(8), .RX_DEPTH(8), .TX_DEPTH(32),
    .FULL_PERIOD(4), .TIMEOUT(200)
  ) u_a (
    .clk        (clk),
    .rstn       (rstn),
    .cpu        (if_a),
    .load_valid (load_valid),
    .load_data  (load_data),
    .log_rd_en  (log_rd_en),
    .log_data   (a_log_data),
    .log_empty  (a_log_empty),
    .rx_count   (a_rx_count),
    .tx_count   (a_tx_count),
    .err        (a_err)
  );

  uart_host_model #(
    .DATA_W(8), .RX_DEPTH(4), .TX_DEPTH(32),
    .FULL_PERIOD(0), .TIMEOUT(0)
  ) u_b (
    .clk        (clk),
    .rstn       (rstn),
    .cpu        (if_b),
    .load_valid (load_valid),
    .load_data  (load_data),
    .log_rd_en  (log_rd_en),
    .log_data   (b_log_data),
    .log_empty  (b_log_empty),
    .rx_count   (b_rx_count),
    .tx_count   (b_tx_count),
    .err        (b_err)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn       = 1'b0;
    load_valid = 1'b0;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    log_rd_en  = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
  endtask

  logic [7:0] t2_exp [3] = '{8'h41, 8'h42, 8'h43};
  logic [7:0] t3_exp [8] = '{8'h11, 8'h12, 8'h13, 8'h14,
                             8'h15, 8'h16, 8'h17, 8'h99};
  logic [7:0] t4_exp [12] = '{8'h00, 8'h01, 8'h02, 8'h04,
                              8'h05, 8'h06, 8'h08, 8'h09,
                              8'h0A, 8'h0C, 8'h0D, 8'h0E};

  initial begin
    do_reset();
    chk("rst_empty", if_a.empty, 1);
    chk("rst_full", if_a.full, 0);
    chk("rst_rx_data", if_a.rx_data, 0);
    chk("rst_log_empty", a_log_empty, 1);
    chk("rst_log_data", a_log_data, 0);
    chk("rst_rx_count", a_rx_count, 0);
    chk("rst_tx_count", a_tx_count, 0);
    chk("rst_err", a_err, 0);

    // in-order FWFT delivery
    load_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      load_data = t2_exp[i];
      tick();
      if (i == 0) chk("t2_empty_fall", if_a.empty, 0);
    end
    load_valid = 1'b0;
    chk("t2_count3", a_rx_count, 3);
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t2_rx_data", if_a.rx_data, t2_exp[i]);
      tick();
    end
    rd_en = 1'b0;
    chk("t2_empty_end", if_a.empty, 1);
    chk("t2_count0", a_rx_count, 0);

    // pop on empty
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("t5_err", a_err, 4'b0010);
    chk("t5_count", a_rx_count, 0);

    // reset asserted mid-traffic
    load_valid = 1'b1; load_data = 8'h55;
    wr_en = 1'b1; tx_data = 8'h66;
    tick(); tick();
    #2 rstn = 1'b0;
    #1;
    chk("t1_empty", if_a.empty, 1);
    chk("t1_full", if_a.full, 0);
    chk("t1_rx_count", a_rx_count, 0);
    chk("t1_tx_count", a_tx_count, 0);
    chk("t1_err", a_err, 0);
    chk("t1_log_empty", a_log_empty, 1);
    chk("t1_rx_data", if_a.rx_data, 0);
    chk("t1_log_data", a_log_data, 0);
    do_reset();

    // RX overflow, then load+pop at full, with pointer wrap
    load_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      load_data = 8'h10 + 8'(i);
      tick();
    end
    load_valid = 1'b0;
    chk("t3_count_full", a_rx_count, 8);
    chk("t3_err", a_err, 4'b0001);
    chk("t3_head", if_a.rx_data, 8'h10);
    load_valid = 1'b1; load_data = 8'h99; rd_en = 1'b1;
    tick();
    load_valid = 1'b0;
    chk("t3_count_same", a_rx_count, 8);
    for (int i = 0; i < 8; i++) begin
      chk("t3_rx_data", if_a.rx_data, t3_exp[i]);
      tick();
    end
    rd_en = 1'b0;
    chk("t3_empty", if_a.empty, 1);
    chk("t3_count0", a_rx_count, 0);

    // TX backpressure vs. none
    do_reset();
    wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tx_data = 8'(i);
      chk("t4_full_a", if_a.full, ((i % 4) == 3));
      chk("t4_full_b", if_b.full, 0);
      tick();
    end
    wr_en = 1'b0;
    chk("t4_txc_a", a_tx_count, 12);
    chk("t4_txc_b", b_tx_count, 16);
    chk("t4_err_a", a_err, 4'b0100);
    chk("t4_err_b", b_err, 0);
    log_rd_en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk("t4_log_b", b_log_data, k);
      if (k < 12) chk("t4_log_a", a_log_data, t4_exp[k]);
      tick();
    end
    log_rd_en = 1'b0;
    chk("t4_log_empty_a", a_log_empty, 1);
    chk("t4_log_empty_b", b_log_empty, 1);
    chk("t4_txc_a0", a_tx_count, 0);

    // idle timeout
    do_reset();
    repeat (199) tick();
    chk("t6_to_199", a_err[ERR_TIMEOUT], 0);
    tick();
    chk("t6_to_200", a_err[ERR_TIMEOUT], 1);
    chk("t6_b_disabled", b_err, 0);

    do_reset();
    repeat (150) tick();
    wr_en = 1'b1; tx_data = 8'h5A;
    tick();
    wr_en = 1'b0;
    chk("t6_wr_logged", a_tx_count, 1);
    repeat (199) tick();
    chk("t6_to_350", a_err[ERR_TIMEOUT], 0);
    tick();
    chk("t6_to_351", a_err[ERR_TIMEOUT], 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
